rising_edge_detector: RTL and testbench

//  Per-channel input conditioner for asynchronous push-button/level inputs.

---
 rtl/rising_edge_detector.sv | 101 ++++++++++
 tb/tb_rising_edge_detector.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/rising_edge_detector.sv
// Per-channel input conditioner: synchronizer, optional debounce, registered rise/fall pulses.
// Define EDGE_DET_DEBOUNCE_EN to insert a DEBOUNCE_CYCLES stability filter after the synchronizer.
module rising_edge_detector #(
    parameter int WIDTH           = 1,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sig,
    output logic [WIDTH-1:0] edg,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] level
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("rising_edge_detector: SYNC_STAGES must be in 2..4");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("rising_edge_detector: DEBOUNCE_CYCLES must be >= 1");
    end

    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [WIDTH-1:0] w_sync_out;
    logic [WIDTH-1:0] w_cond;
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_edg;
    logic [WIDTH-1:0] r_fall;
    logic [WIDTH-1:0] r_level;

    // NOTE: every stage of the synchronizer is cleared on reset so a level
    // held through reset reappears as a fresh edge once reset drops.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                r_sync[k] <= '0;
            end
        end else begin
            r_sync[0] <= sig;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                r_sync[k] <= r_sync[k-1];
            end
        end
    end

    assign w_sync_out = r_sync[SYNC_STAGES-1];

`ifdef EDGE_DET_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt [WIDTH];
    logic [WIDTH-1:0] r_clean;

    // Level only follows the synchronizer after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_clean <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (w_sync_out[i] == r_clean[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_LAST) begin
                    r_clean[i] <= w_sync_out[i];
                    r_cnt[i]   <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign w_cond = r_clean;
`else
    assign w_cond = w_sync_out;
`endif

    // NOTE: non-blocking assignments let r_prev hold last cycle's level while
    // the pulse logic reads it in the same clock edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev  <= '0;
            r_edg   <= '0;
            r_fall  <= '0;
            r_level <= '0;
        end else begin
            r_prev  <= w_cond;
            r_edg   <= w_cond & ~r_prev;
            r_fall  <= ~w_cond & r_prev;
            r_level <= w_cond;
        end
    end

    assign edg   = r_edg;
    assign fall  = r_fall;
    assign level = r_level;

endmodule

// File: tb/tb_rising_edge_detector.sv
// Self-checking bench for rising_edge_detector: directed scenarios plus random
// stimulus compared against a history-based reference model.
module tb_rising_edge_detector;

    localparam int W = 3;
    localparam int S = 2;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] sig;
    logic [W-1:0] edg;
    logic [W-1:0] fall;
    logic [W-1:0] level;

    rising_edge_detector #(
        .WIDTH(W),
        .SYNC_STAGES(S),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .sig  (sig),
        .edg  (edg),
        .fall (fall),
        .level(level)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model state: full history of what was sampled at each edge.
    logic [W-1:0] hs[$];   // sig sampled at edge k
    bit           hr[$];   // reset sampled at edge k
    logic [W-1:0] hsy[$];  // synchronizer output after edge k
    logic [W-1:0] hc[$];   // conditioned level after edge k
    int           run[W];
    logic [W-1:0] exp_edg, exp_fall, exp_level;

    // Scenario statistics.
    int           step_no;
    int           e_cnt, f_cnt, e_first, f_first;
    logic [W-1:0] e_val;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Synchronizer output after edge k: the input sampled S-1 edges earlier,
    // forced low if any reset occurred in that window.
    function automatic logic [W-1:0] sync_at(input int k);
        if (k - S + 1 < 0) return '0;
        for (int j = k - S + 1; j <= k; j++) begin
            if (hr[j]) return '0;
        end
        return hs[k-S+1];
    endfunction

    task automatic model_push(input logic [W-1:0] s, input bit r);
        int           k;
        logic [W-1:0] sy, c, cm1, pm1;
        hs.push_back(s);
        hr.push_back(r);
        k  = hs.size() - 1;
        sy = sync_at(k);
        hsy.push_back(sy);
`ifdef EDGE_DET_DEBOUNCE_EN
        begin
            logic [W-1:0] old_c, seen;
            old_c = (k > 0) ? hc[k-1] : '0;
            seen  = (k > 0) ? hsy[k-1] : '0;
            c     = old_c;
            for (int i = 0; i < W; i++) begin
                if (r || seen[i] == old_c[i]) begin
                    run[i] = 0;
                end else begin
                    run[i]++;
                    if (run[i] == D) begin
                        c[i]   = seen[i];
                        run[i] = 0;
                    end
                end
            end
            if (r) c = '0;
        end
`else
        c = sy;
`endif
        hc.push_back(c);
        cm1 = (k >= 1) ? hc[k-1] : '0;
        pm1 = (k >= 2 && !hr[k-1]) ? hc[k-2] : '0;
        if (r) begin
            exp_level = '0;
            exp_edg   = '0;
            exp_fall  = '0;
        end else begin
            exp_level = cm1;
            exp_edg   = cm1 & ~pm1;
            exp_fall  = ~cm1 & pm1;
        end
    endtask

    task automatic clear_stats();
        step_no = 0;
        e_cnt   = 0;
        f_cnt   = 0;
        e_first = -1;
        f_first = -1;
        e_val   = '0;
    endtask

    task automatic step(input logic [W-1:0] s, input bit r);
        @(negedge clk);
        sig   = s;
        reset = r;
        @(posedge clk);
        model_push(s, r);
        #1;
        step_no++;
        check("level", 32'(level), 32'(exp_level));
        check("edg", 32'(edg), 32'(exp_edg));
        check("fall", 32'(fall), 32'(exp_fall));
        check("edg_fall_exclusive", 32'(edg & fall), 32'd0);
        if (edg != '0) begin
            e_cnt++;
            if (e_first < 0) begin
                e_first = step_no;
                e_val   = edg;
            end
        end
        if (fall != '0) begin
            f_cnt++;
            if (f_first < 0) f_first = step_no;
        end
    endtask

    task automatic hold(input logic [W-1:0] s, input int n);
        for (int i = 0; i < n; i++) step(s, 1'b0);
    endtask

    initial begin
        sig   = '0;
        reset = 1'b1;

        // Reset for three cycles with sig low, then idle.
        clear_stats();
        for (int i = 0; i < 3; i++) step('0, 1'b1);
        hold('0, 2);
        check("reset_outputs", 32'({edg, fall, level}), 32'd0);

`ifndef EDGE_DET_DEBOUNCE_EN
        // Single rise on channel 0 held 10 cycles.
        clear_stats();
        hold(3'b001, 10);
        check("rise_edg_count", 32'(e_cnt), 32'd1);
        check("rise_edg_cycle", 32'(e_first), 32'd3);
        check("rise_edg_value", 32'(e_val), 32'h1);
        check("rise_no_fall", 32'(f_cnt), 32'd0);

        // Release: one fall pulse, no edg.
        clear_stats();
        hold(3'b000, 6);
        check("fall_count", 32'(f_cnt), 32'd1);
        check("fall_cycle", 32'(f_first), 32'd3);
        check("fall_no_edg", 32'(e_cnt), 32'd0);

        // Multi-channel rises.
        clear_stats();
        hold(3'b101, 6);
        check("multi_edg_count", 32'(e_cnt), 32'd1);
        check("multi_edg_value", 32'(e_val), 32'h5);
        clear_stats();
        hold(3'b111, 6);
        check("mid_edg_count", 32'(e_cnt), 32'd1);
        check("mid_edg_value", 32'(e_val), 32'h2);
        hold(3'b000, 6);

        // Reset one cycle after the rise aborts the pending pulse; sig held high
        // through reset produces exactly one edg after release.
        clear_stats();
        step(3'b001, 1'b0);
        step(3'b001, 1'b1);
        hold(3'b001, 2);
        check("abort_no_edg", 32'(e_cnt), 32'd0);
        clear_stats();
        step(3'b001, 1'b1);
        hold(3'b001, 6);
        check("post_reset_edg_count", 32'(e_cnt), 32'd1);
        check("post_reset_edg_cycle", 32'(e_first), 32'd4);
        hold(3'b000, 6);
`endif

        // Toggle channel 1 every cycle: edg and fall must alternate.
        clear_stats();
        for (int i = 0; i < 12; i++) step((i % 2 == 0) ? 3'b010 : 3'b000, 1'b0);
        hold(3'b000, 6);

        // Random bursts with occasional reset.
        for (int n = 0; n < 150; n++) begin
            logic [W-1:0] v;
            int           len;
            bit           r;
            v   = W'($urandom);
            len = int'($urandom_range(1, 8));
            r   = ($urandom_range(0, 24) == 0);
            for (int i = 0; i < len; i++) step(v, (i == 0) ? r : 1'b0);
        end
        hold(3'b000, 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
